// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Bit-serial adder/subtractor: one full-adder cell processes one operand bit
//   per clock, LSB first. Subtraction is A + ~B + 1, with the +1 injected as
//   the initial carry. The result is held until the next operation finishes.
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  begin an operation (honoured in IDLE or DONE only)
//   sub    0 = A+B, 1 = A-B (captured with start)
//   a, b   operands (captured with start)
//   busy   high while the serial pass is running
//   done   one-cycle pulse when sum/cout/ovf have just been updated
//   sum    result modulo 2^WIDTH
//   cout   carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf    signed overflow (carry into MSB ^ carry out of MSB)
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] ps_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic             s_s;
  logic             c_s;
  logic [WIDTH-1:0] ps_s;
  logic             last_s;
  logic             load_s;

  function automatic logic maj(input logic x, input logic y, input logic z);
    maj = (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder cell on the current LSBs plus next-state decode.
  always_comb begin
    s_s        = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
    c_s        = maj(a_sh_r[0], b_sh_r[0], carry_r);
    ps_s       = {s_s, ps_r[WIDTH-1:1]};
    last_s     = (cnt_r == CW'(WIDTH - 1));
    load_s     = 1'b0;
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath shift registers and registered result/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      ps_r    <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s == ST_RUN);
      done    <= (state_nx_s == ST_DONE);
      if (load_s) begin
        a_sh_r  <= a;
        b_sh_r  <= sub ? ~b : b;
        carry_r <= sub;
        cnt_r   <= '0;
        ps_r    <= '0;
      end else if (state_r == ST_RUN) begin
        a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
        ps_r    <= ps_s;
        carry_r <= c_s;
        cnt_r   <= cnt_r + CW'(1);
        if (last_s) begin
          // carry_r here is the carry into the MSB, c_s the carry out of it.
          sum  <= ps_s;
          cout <= c_s;
          ovf  <= carry_r ^ c_s;
        end else begin
          sum  <= sum;
          cout <= cout;
          ovf  <= ovf;
        end
      end else begin
        a_sh_r  <= a_sh_r;
        b_sh_r  <= b_sh_r;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  logic [W+1:0] expq[$];   // {cout, ovf, sum}
  logic         prev_done = 1'b0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks protocol rules.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        check("done_not_busy", {31'd0, busy}, 32'd0);
        check("done_single", {31'd0, prev_done}, 32'd0);
        if (expq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [W+1:0] e;
          e = expq.pop_front();
          check("result", {22'd0, cout, ovf, sum}, {22'd0, e});
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    a = ta; b = tb; sub = ts; start = 1'b1;
  endtask

  // Waits for done (sampled #1 after each posedge); returns edges since call.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 30) begin
      @(posedge clk); #1; n++;
      if (done === 1'b1) break;
    end
    if (done !== 1'b1) check("timeout", 32'd1, 32'd0);
  endtask

  // One operation: start captured at E0, done expected 8 edges later.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    drive(ta, tb, ts);
    @(posedge clk); #1;
    expq.push_back({ec, eo, es});
    start = 1'b0;
    wait_done(n);
    check("latency", n, 32'd8);
  endtask

  int n;

  initial begin
    rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 8'hAA; b = 8'h55;
    // T1 reset with start held high
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // T2 add
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    // T3 sub
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("hold_sum_idle", {24'd0, sum}, 32'h7F);

    // T4 start pulsed mid-run with new operands: ignored
    drive(8'h01, 8'h02, 1'b0);
    @(posedge clk); #1;
    expq.push_back({1'b0, 1'b0, 8'h03});
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1; drive(8'hF0, 8'hF0, 1'b1);
    @(posedge clk); #1; start = 1'b0; a = 8'h00; b = 8'h00;
    wait_done(n);
    check("t4_latency", n + 3, 32'd8);
    @(posedge clk); #1;
    check("t4_no_second_done", {31'd0, done}, 32'd0);

    // T5 back-to-back with start held high
    drive(8'h11, 8'h22, 1'b0);              // 0x33
    @(posedge clk); #1;
    expq.push_back({1'b0, 1'b0, 8'h33});
    drive(8'h7F, 8'h01, 1'b0);              // 0x80, ovf
    for (int k = 0; k < 8; k++) begin
      check("t5_busy_run", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    check("t5_done1", {31'd0, done}, 32'd1);
    check("t5_busy_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;                     // reload op2
    expq.push_back({1'b0, 1'b1, 8'h80});
    drive(8'h05, 8'h07, 1'b1);              // 0xFE, borrow
    for (int k = 0; k < 8; k++) begin
      check("t5_busy_run2", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    check("t5_done2", {31'd0, done}, 32'd1);
    @(posedge clk); #1;                     // reload op3
    expq.push_back({1'b0, 1'b0, 8'hFE});
    start = 1'b0;
    wait_done(n);
    check("t5_period", n, 32'd8);
    @(posedge clk); #1;

    // T6 reset mid-op
    drive(8'h33, 8'h44, 1'b0);
    @(posedge clk); #1;                     // E0
    start = 1'b0;
    repeat (3) @(posedge clk);              // RUN edges 1..3
    #1; rst_n = 1'b0;
    @(posedge clk); #1;                     // 4th RUN edge: reset
    rst_n = 1'b1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_sum",  {24'd0, sum},  32'd0);
    for (int k = 0; k < 10; k++) begin
      check("t6_no_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    run_op(8'hC8, 8'h64, 1'b1, 8'h64, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    check("queue_empty", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
